// File: rtl/cache_pkg.sv
// Shared types and helpers for the set-associative cache: FSM states,
// replacement policy codes and CPU address field extraction.
package cache_pkg;

  typedef enum logic [1:0] {IDLE, SWAP_OUT, SWAP_IN, SWAP_IN_OK} state_t;

  localparam int POLICY_FIFO = 0;
  localparam int POLICY_LRU  = 1;
  localparam int WORD_W      = 32;

  // Returns addr[lsb +: width] right-aligned in a 32-bit word.
  function automatic logic [31:0] addr_field(input logic [31:0] a, input int lsb, input int width);
    logic [31:0] mask;
    mask = (width >= 32) ? '1 : ((32'h1 << width) - 32'h1);
    return (a >> lsb) & mask;
  endfunction

endpackage

// File: rtl/cache_repl.sv
// Per-set replacement state and victim choice; invalid ways are always
// taken first, otherwise a FIFO pointer or true-LRU ages decide.
module cache_repl
  import cache_pkg::*;
#(
  parameter int SET_ADDR_LEN = 3,
  parameter int WAY_CNT      = 4,
  parameter int POLICY       = POLICY_FIFO
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [SET_ADDR_LEN-1:0]    set_idx,
  input  logic [$clog2(WAY_CNT)-1:0] way_idx,
  input  logic                       access,
  input  logic                       fill,
  input  logic [WAY_CNT-1:0]         valid,
  output logic [$clog2(WAY_CNT)-1:0] victim
);
  localparam int SETS  = 1 << SET_ADDR_LEN;
  localparam int WAY_W = $clog2(WAY_CNT);

  logic [WAY_W-1:0] policy_victim;

  always_comb begin
    logic found;
    found  = 1'b0;
    victim = policy_victim;
    for (int w = 0; w < WAY_CNT; w++) begin
      if (!valid[w] && !found) begin
        victim = WAY_W'(w);
        found  = 1'b1;
      end
    end
  end

  generate
    if (POLICY == POLICY_LRU) begin : g_lru
      logic [WAY_W-1:0] age [SETS][WAY_CNT];
      logic [WAY_W-1:0] acc_age;

      // A fill into an empty way behaves as if that way were the oldest.
      assign acc_age = (fill && !valid[way_idx]) ? WAY_W'(WAY_CNT - 1) : age[set_idx][way_idx];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAY_CNT; w++)
              age[s][w] <= '0;
        end else if (access || fill) begin
          for (int w = 0; w < WAY_CNT; w++) begin
            if (WAY_W'(w) == way_idx)
              age[set_idx][w] <= '0;
            else if (valid[w] && age[set_idx][w] < acc_age)
              age[set_idx][w] <= age[set_idx][w] + 1'b1;
          end
        end
      end

      always_comb begin
        policy_victim = '0;
        for (int w = WAY_CNT - 1; w >= 0; w--)
          if (age[set_idx][w] == WAY_W'(WAY_CNT - 1)) policy_victim = WAY_W'(w);
      end
    end else begin : g_fifo
      logic [WAY_W-1:0] ptr [SETS];
      logic             unused_ports;

      assign unused_ports  = access ^ (^way_idx);
      assign policy_victim = ptr[set_idx];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int s = 0; s < SETS; s++) ptr[s] <= '0;
        end else if (fill) begin
          ptr[set_idx] <= ptr[set_idx] + 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/main_mem.sv
// Line-granular backing memory: a request is granted in its LATENCY-th cycle;
// writes commit on the grant edge, reads are valid while gnt is high.
module main_mem #(
  parameter int ADDR_W  = 9,
  parameter int LINE_W  = 256,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LINE_W-1:0] wr_line,
  output logic [LINE_W-1:0] rd_line,
  output logic              gnt
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int CW    = $clog2(LATENCY + 1);

  logic [LINE_W-1:0] mem [DEPTH];
  logic [CW-1:0]     cnt;

  assign gnt     = (rd_req | wr_req) && (cnt == CW'(LATENCY - 1));
  assign rd_line = mem[addr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 cnt <= '0;
    else if (gnt)             cnt <= '0;
    else if (rd_req | wr_req) cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_req && gnt) mem[addr] <= wr_line;
  end

endmodule

// File: rtl/cache_assoc_policy.sv
// Write-back, write-allocate N-way set-associative cache with selectable
// FIFO/LRU replacement and saturating hit/miss counters.
module cache_assoc_policy
  import cache_pkg::*;
#(
  parameter int LINE_ADDR_LEN = 3,
  parameter int SET_ADDR_LEN  = 3,
  parameter int TAG_ADDR_LEN  = 6,
  parameter int WAY_CNT       = 4,
  parameter int POLICY        = POLICY_FIFO,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      addr,
  input  logic             rd_req,
  input  logic             wr_req,
  input  logic [31:0]      wr_data,
  output logic [31:0]      rd_data,
  output logic             miss,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);
  localparam int SETS       = 1 << SET_ADDR_LEN;
  localparam int WAY_W      = $clog2(WAY_CNT);
  localparam int LINE_W     = WORD_W << LINE_ADDR_LEN;
  localparam int MEM_ADDR_W = TAG_ADDR_LEN + SET_ADDR_LEN;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t                  state;
  logic                    retry;
  logic [WAY_CNT-1:0]      valid [SETS];
  logic [WAY_CNT-1:0]      dirty [SETS];
  logic [TAG_ADDR_LEN-1:0] tags  [SETS][WAY_CNT];
  logic [LINE_W-1:0]       lines [SETS][WAY_CNT];

  logic [LINE_ADDR_LEN-1:0] line_a;
  logic [SET_ADDR_LEN-1:0]  set_a, set_q, set_sel;
  logic [TAG_ADDR_LEN-1:0]  tag_a, tag_q;
  logic [WAY_W-1:0]         hit_way, victim, vic_q, way_sel;
  logic                     hit, req, idle_req;
  logic [MEM_ADDR_W-1:0]    wb_addr, mem_addr;
  logic [LINE_W-1:0]        wb_line, fill_line, mem_rd_line;
  logic                     mem_rd_req, mem_wr_req, mem_gnt;

  assign line_a = LINE_ADDR_LEN'(addr_field(addr, 2, LINE_ADDR_LEN));
  assign set_a  = SET_ADDR_LEN'(addr_field(addr, 2 + LINE_ADDR_LEN, SET_ADDR_LEN));
  assign tag_a  = TAG_ADDR_LEN'(addr_field(addr, 2 + LINE_ADDR_LEN + SET_ADDR_LEN, TAG_ADDR_LEN));

  // At most one way can match; the lowest index is taken regardless.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAY_CNT; w++) begin
      if (!hit && valid[set_a][w] && tags[set_a][w] == tag_a) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  assign req      = rd_req | wr_req;
  assign idle_req = (state == IDLE) && req;
  assign miss     = req & ~(hit & (state == IDLE));

  assign set_sel = (state == SWAP_IN_OK) ? set_q : set_a;
  assign way_sel = (state == SWAP_IN_OK) ? vic_q : hit_way;

  cache_repl #(
    .SET_ADDR_LEN (SET_ADDR_LEN),
    .WAY_CNT      (WAY_CNT),
    .POLICY       (POLICY)
  ) u_repl (
    .clk     (clk),
    .rst     (rst),
    .set_idx (set_sel),
    .way_idx (way_sel),
    .access  (idle_req && hit),
    .fill    (state == SWAP_IN_OK),
    .valid   (valid[set_sel]),
    .victim  (victim)
  );

  assign mem_wr_req = (state == SWAP_OUT);
  assign mem_rd_req = (state == SWAP_IN);
  assign mem_addr   = (state == SWAP_OUT) ? wb_addr : {tag_q, set_q};

  main_mem #(
    .ADDR_W (MEM_ADDR_W),
    .LINE_W (LINE_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .rd_req  (mem_rd_req),
    .wr_req  (mem_wr_req),
    .addr    (mem_addr),
    .wr_line (wb_line),
    .rd_line (mem_rd_line),
    .gnt     (mem_gnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      retry    <= 1'b0;
      rd_data  <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        dirty[s] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            retry <= 1'b0;
            if (hit) begin
              if (!retry) hit_cnt <= sat_inc(hit_cnt);
              if (rd_req) rd_data <= lines[set_a][hit_way][{line_a, 5'b0} +: WORD_W];
              else        dirty[set_a][hit_way] <= 1'b1;
            end else begin
              miss_cnt <= sat_inc(miss_cnt);
              state    <= (valid[set_a][victim] && dirty[set_a][victim]) ? SWAP_OUT : SWAP_IN;
            end
          end
        end
        SWAP_OUT: if (mem_gnt) state <= SWAP_IN;
        SWAP_IN:  if (mem_gnt) state <= SWAP_IN_OK;
        SWAP_IN_OK: begin
          valid[set_q][vic_q] <= 1'b1;
          dirty[set_q][vic_q] <= 1'b0;
          retry               <= 1'b1;
          state               <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line storage, tags and miss bookkeeping carry no reset.
  always_ff @(posedge clk) begin
    if (idle_req && !hit) begin
      tag_q   <= tag_a;
      set_q   <= set_a;
      vic_q   <= victim;
      wb_addr <= {tags[set_a][victim], set_a};
      wb_line <= lines[set_a][victim];
    end
    if (state == SWAP_IN && mem_gnt) fill_line <= mem_rd_line;
    if (state == SWAP_IN_OK) begin
      lines[set_q][vic_q] <= fill_line;
      tags[set_q][vic_q]  <= tag_q;
    end else if (idle_req && hit && !rd_req) begin
      lines[set_a][hit_way][{line_a, 5'b0} +: WORD_W] <= wr_data;
    end
  end

endmodule

// File: tb/tb_cache_assoc_policy.sv
// Bench for cache_assoc_policy: a FIFO instance (32-bit counters) and an LRU
// instance (4-bit counters) driven by scenario tasks with a read-data scoreboard.
module tb_cache_assoc_policy;
  localparam int MEM_LAT     = 4;
  localparam int CLEAN_STALL = MEM_LAT + 2;
  localparam int DIRTY_STALL = 2 * MEM_LAT + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr_v    [2];
  logic        rd_req_v  [2];
  logic        wr_req_v  [2];
  logic [31:0] wr_data_v [2];
  logic [31:0] rd_data_v [2];
  logic        miss_v    [2];
  logic [31:0] hc0, mc0;
  logic [3:0]  hc1, mc1;

  int vectors = 0;
  int errors  = 0;

  typedef struct {
    int          d;
    logic [31:0] data;
    string       name;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  cache_assoc_policy #(.POLICY(0), .CNT_W(32)) dut_fifo (
    .clk(clk), .rst(rst), .addr(addr_v[0]), .rd_req(rd_req_v[0]), .wr_req(wr_req_v[0]),
    .wr_data(wr_data_v[0]), .rd_data(rd_data_v[0]), .miss(miss_v[0]),
    .hit_cnt(hc0), .miss_cnt(mc0)
  );

  cache_assoc_policy #(.POLICY(1), .CNT_W(4)) dut_lru (
    .clk(clk), .rst(rst), .addr(addr_v[1]), .rd_req(rd_req_v[1]), .wr_req(wr_req_v[1]),
    .wr_data(wr_data_v[1]), .rd_data(rd_data_v[1]), .miss(miss_v[1]),
    .hit_cnt(hc1), .miss_cnt(mc1)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      rd_req_v[d] = 1'b0; wr_req_v[d] = 1'b0; addr_v[d] = '0; wr_data_v[d] = '0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // One CPU access held until miss drops; stall = cycles seen with miss high.
  task automatic access(input int d, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input bit chk, input logic [31:0] exp_rd,
                        input string name, output int stall);
    exp_t e;
    int   n;
    @(negedge clk);
    addr_v[d] = a; wr_data_v[d] = wd; rd_req_v[d] = rd; wr_req_v[d] = wr;
    if (rd && chk) begin
      e.d = d; e.data = exp_rd; e.name = name;
      sb.push_back(e);
    end
    #1;
    n = 0;
    while (miss_v[d] && n < 100) begin
      n++;
      @(negedge clk); #1;
    end
    stall = n;
    if (miss_v[d]) begin
      vectors++; errors++;
      $display("FAIL %s_timeout: miss still high after %0d cycles", name, n);
    end
    @(posedge clk); #1;
    rd_req_v[d] = 1'b0; wr_req_v[d] = 1'b0;
    if (rd && chk) begin
      e = sb.pop_front();
      vectors++;
      if (rd_data_v[e.d] !== e.data) begin
        errors++;
        $display("FAIL %s: rd_data=%h expected %h", e.name, rd_data_v[e.d], e.data);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (rd_data_v[d] !== 32'h0 || miss_v[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_out%0d: rd_data=%h miss=%b expected 0/0", d, rd_data_v[d], miss_v[d]);
      end
    end
    vectors++;
    if (hc0 !== 32'd0 || mc0 !== 32'd0 || hc1 !== 4'd0 || mc1 !== 4'd0) begin
      errors++;
      $display("FAIL reset_cnt: hc0=%0d mc0=%0d hc1=%0d mc1=%0d expected all 0", hc0, mc0, hc1, mc1);
    end
  endtask

  task automatic test_cold_write_back();
    int st;
    logic [31:0] fills [3] = '{32'h104, 32'h204, 32'h304};
    access(0, 0, 1, 32'h4, 32'hDEADBEEF, 0, 0, "cold_wr", st);
    vectors++;
    if (st !== CLEAN_STALL || mc0 !== 32'd1 || hc0 !== 32'd0) begin
      errors++;
      $display("FAIL cold_wr_miss: stall=%0d mc=%0d hc=%0d expected %0d/1/0", st, mc0, hc0, CLEAN_STALL);
    end
    access(0, 1, 0, 32'h4, 0, 1, 32'hDEADBEEF, "cold_rd", st);
    vectors++;
    if (st !== 0 || hc0 !== 32'd1) begin
      errors++;
      $display("FAIL cold_rd_hit: stall=%0d hc=%0d expected 0/1", st, hc0);
    end
    foreach (fills[i]) begin
      access(0, 1, 0, fills[i], 0, 0, 0, "fill", st);
      vectors++;
      if (st !== CLEAN_STALL) begin
        errors++;
        $display("FAIL fill_%h: stall=%0d expected %0d", fills[i], st, CLEAN_STALL);
      end
    end
    access(0, 1, 0, 32'h404, 0, 0, 0, "evict", st);
    vectors++;
    if (st !== DIRTY_STALL) begin
      errors++;
      $display("FAIL evict_dirty_stall: stall=%0d expected %0d", st, DIRTY_STALL);
    end
    access(0, 1, 0, 32'h4, 0, 1, 32'hDEADBEEF, "reread_from_mem", st);
    vectors++;
    if (st !== CLEAN_STALL || mc0 !== 32'd6 || hc0 !== 32'd1) begin
      errors++;
      $display("FAIL reread_cnt: stall=%0d mc=%0d hc=%0d expected %0d/6/1", st, mc0, hc0, CLEAN_STALL);
    end
  endtask

  task automatic run_policy_seq(input int d, input bit exp_miss [8], input string tag);
    int st;
    logic [31:0] seq [8] = '{32'h000, 32'h100, 32'h200, 32'h300, 32'h000, 32'h400, 32'h000, 32'h100};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      access(d, 1, 0, seq[i], 0, 0, 0, tag, st);
      vectors++;
      if ((st != 0) !== exp_miss[i]) begin
        errors++;
        $display("FAIL %s_step%0d addr=%h: missed=%b expected %b", tag, i, seq[i], st != 0, exp_miss[i]);
      end
    end
  endtask

  task automatic test_fifo();
    bit em [8] = '{1, 1, 1, 1, 0, 1, 1, 1};
    run_policy_seq(0, em, "fifo");
  endtask

  task automatic test_lru();
    bit em [8] = '{1, 1, 1, 1, 0, 1, 0, 1};
    run_policy_seq(1, em, "lru");
  endtask

  task automatic test_rd_wr_priority();
    int st;
    logic [31:0] ev1 [4] = '{32'h108, 32'h208, 32'h308, 32'h408};
    logic [31:0] ev2 [3] = '{32'h508, 32'h608, 32'h708};
    do_reset();
    access(0, 0, 1, 32'h8, 32'h11, 0, 0, "prio_wr", st);
    foreach (ev1[i]) access(0, 1, 0, ev1[i], 0, 0, 0, "prio_ev1", st);
    access(0, 1, 0, 32'h8, 0, 1, 32'h11, "prio_refill", st);
    access(0, 1, 1, 32'h8, 32'h99, 1, 32'h11, "prio_rdwr", st);
    vectors++;
    if (st !== 0) begin
      errors++;
      $display("FAIL prio_rdwr_hit: stall=%0d expected 0", st);
    end
    access(0, 1, 0, 32'h8, 0, 1, 32'h11, "prio_line_unchanged", st);
    foreach (ev2[i]) access(0, 1, 0, ev2[i], 0, 0, 0, "prio_ev2", st);
    access(0, 1, 0, 32'h808, 0, 0, 0, "prio_ev_clean", st);
    vectors++;
    if (st !== CLEAN_STALL) begin
      errors++;
      $display("FAIL prio_not_dirty: stall=%0d expected %0d", st, CLEAN_STALL);
    end
    access(0, 1, 0, 32'h8, 0, 1, 32'h11, "prio_mem_unchanged", st);
  endtask

  task automatic test_reset_mid_refill();
    int st;
    do_reset();
    access(0, 0, 1, 32'h20, 32'h5A5A, 0, 0, "mid_wr", st);
    access(0, 1, 0, 32'h20, 0, 1, 32'h5A5A, "mid_rd", st);
    @(negedge clk);
    addr_v[0] = 32'h1E0; rd_req_v[0] = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if (mc0 !== 32'd2 || hc0 !== 32'd1) begin
      errors++;
      $display("FAIL mid_pre_cnt: mc=%0d hc=%0d expected 2/1", mc0, hc0);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (rd_data_v[0] !== 32'h0 || hc0 !== 32'd0 || mc0 !== 32'd0) begin
      errors++;
      $display("FAIL mid_async_reset: rd_data=%h hc=%0d mc=%0d expected 0/0/0", rd_data_v[0], hc0, mc0);
    end
    rd_req_v[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    access(0, 1, 0, 32'h000, 0, 0, 0, "mid_after", st);
    vectors++;
    if (st !== CLEAN_STALL || mc0 !== 32'd1) begin
      errors++;
      $display("FAIL mid_after_miss: stall=%0d mc=%0d expected %0d/1", st, mc0, CLEAN_STALL);
    end
  endtask

  task automatic test_saturation();
    int st;
    do_reset();
    access(1, 1, 0, 32'h000, 0, 0, 0, "sat_miss", st);
    vectors++;
    if (hc1 !== 4'd0 || mc1 !== 4'd1) begin
      errors++;
      $display("FAIL sat_retry_uncounted: hc=%0d mc=%0d expected 0/1", hc1, mc1);
    end
    repeat (5) access(1, 1, 0, 32'h000, 0, 0, 0, "sat_hit", st);
    vectors++;
    if (hc1 !== 4'd5) begin
      errors++;
      $display("FAIL sat_hit5: hc=%0d expected 5", hc1);
    end
    repeat (10) access(1, 1, 0, 32'h000, 0, 0, 0, "sat_hit", st);
    vectors++;
    if (hc1 !== 4'hF) begin
      errors++;
      $display("FAIL sat_hit15: hc=%0d expected 15", hc1);
    end
    repeat (3) access(1, 1, 0, 32'h000, 0, 0, 0, "sat_hit", st);
    vectors++;
    if (hc1 !== 4'hF || mc1 !== 4'd1) begin
      errors++;
      $display("FAIL sat_hold: hc=%0d mc=%0d expected 15/1", hc1, mc1);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rd_req_v[d] = 1'b0; wr_req_v[d] = 1'b0; addr_v[d] = '0; wr_data_v[d] = '0;
    end
    test_reset();
    test_cold_write_back();
    test_fifo();
    test_lru();
    test_rd_wr_priority();
    test_reset_mid_refill();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
